img_mem_fsm: RTL and testbench

//  Memory-sequencing FSM placed directly downstream of the control block; its
//  o_EOP drives the control block's i_EOP_from_FSM.

---
 rtl/img_mem_fsm_pkg.sv | 20 ++
 rtl/img_mem_fsm_col_assembler.sv | 58 +++++
 rtl/img_mem_fsm.sv | 181 ++++++++++++++++++
 tb/tb_img_mem_fsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/img_mem_fsm_pkg.sv
// Shared encodings for the image-band memory sequencer, the control block and the conv datapath.
package img_mem_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Band row that a read address belongs to; also tags data coming back from the BRAM.
  typedef enum logic [1:0] {
    PH_ROW0 = 2'd0,
    PH_ROW1 = 2'd1,
    PH_ROW2 = 2'd2
  } phase_t;

  localparam int PIX_W_DEF = 8;

endpackage

// File: rtl/img_mem_fsm_col_assembler.sv
// Re-aligns band BRAM read data with its row tag and packs three rows into one pixel column.
// The strobe rises on the edge that captures the row2 pixel.
module col_assembler
  import img_mem_fsm_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic               i_rd_vld,
  input  phase_t             i_rd_ph,
  input  logic [PIX_W-1:0]   i_mem_rdata,
  output logic [3*PIX_W-1:0] o_col,
  output logic               o_col_valid
);

  logic [RD_LAT-1:0] r_vld_dl;
  phase_t            r_ph_dl [RD_LAT];
  logic [PIX_W-1:0]  r_row0;
  logic [PIX_W-1:0]  r_row1;
  logic              w_vld;
  phase_t            w_ph;

  assign w_vld = r_vld_dl[RD_LAT-1];
  assign w_ph  = r_ph_dl[RD_LAT-1];

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      r_vld_dl    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_ph_dl[i] <= PH_ROW0;
      r_row0      <= '0;
      r_row1      <= '0;
      o_col       <= '0;
      o_col_valid <= 1'b0;
    end else begin
      r_vld_dl[0] <= i_rd_vld;
      r_ph_dl[0]  <= i_rd_ph;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_dl[i] <= r_vld_dl[i-1];
        r_ph_dl[i]  <= r_ph_dl[i-1];
      end
      o_col_valid <= 1'b0;
      if (w_vld) begin
        case (w_ph)
          PH_ROW0: r_row0 <= i_mem_rdata;
          PH_ROW1: r_row1 <= i_mem_rdata;
          PH_ROW2: begin
            o_col       <= {i_mem_rdata, r_row1, r_row0};
            o_col_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/img_mem_fsm.sv
// Band memory sequencer: MCU pixel load into the band BRAM, column-wise read-out to the
// conv datapath, and paced result read-out; o_EOP feeds the control block.
module img_mem_fsm
  import img_mem_fsm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic               i_CLK,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_valid,
  input  logic               i_run,
  input  logic [9:0]         i_imgLength,
  input  logic [PIX_W-1:0]   i_pixel,
  input  logic [PIX_W-1:0]   i_mem_rdata,
  output logic               o_we,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [PIX_W-1:0]   o_wr_data,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic [3*PIX_W-1:0] o_col,
  output logic               o_col_valid,
  output logic [9:0]         o_out_addr,
  output logic               o_out_req,
  output logic               o_EOP,
  output logic [1:0]         o_state,
  output logic               o_overflow
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [9:0]        r_n;
  logic [9:0]        r_c;
  phase_t            r_ph;
  logic              r_rd_vld;
  logic [9:0]        r_strb_cnt;
  logic [9:0]        r_out_cnt;

  logic [ADDR_W-1:0] w_n3_live;
  logic [ADDR_W-1:0] w_base1;
  logic [ADDR_W-1:0] w_base2;
  logic [ADDR_W-1:0] w_c_ext;
  logic [9:0]        w_c_nxt;
  logic [9:0]        w_res_cnt;
  logic              w_col_vld;

  // r_wr_cnt counts writes done; a write is allowed while it is below 3*N.
  assign w_n3_live = ADDR_W'(i_imgLength) + (ADDR_W'(i_imgLength) << 1);
  assign w_base1   = ADDR_W'(r_n);
  assign w_base2   = ADDR_W'(r_n) << 1;
  assign w_c_ext   = ADDR_W'(r_c);
  assign w_c_nxt   = r_c + 10'd1;
  assign w_res_cnt = (r_n < 10'd3) ? 10'd0 : r_n - 10'd2;
  assign o_state   = r_state;
  assign o_col_valid = w_col_vld;

  always_ff @(posedge i_CLK) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_n        <= '0;
      r_c        <= '0;
      r_ph       <= PH_ROW0;
      r_rd_vld   <= 1'b0;
      r_strb_cnt <= '0;
      r_out_cnt  <= '0;
      o_we       <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_rd_addr  <= '0;
      o_out_addr <= '0;
      o_out_req  <= 1'b0;
      o_EOP      <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_we      <= 1'b0;
      o_out_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_state    <= ST_LOAD;
            r_wr_cnt   <= '0;
            o_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_run) begin
            r_state    <= ST_RUN;
            r_n        <= i_imgLength;
            r_c        <= '0;
            r_ph       <= PH_ROW0;
            r_strb_cnt <= '0;
            r_rd_vld   <= (i_imgLength >= 10'd3);
            o_rd_addr  <= '0;
          end else if (i_load) begin
            r_wr_cnt <= '0;
          end else if (i_valid) begin
            if (r_wr_cnt < w_n3_live) begin
              o_we      <= 1'b1;
              o_wr_addr <= r_wr_cnt;
              o_wr_data <= i_pixel;
              r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
            end else begin
              o_overflow <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (r_n < 10'd3) begin
            r_state   <= ST_OUT;
            o_EOP     <= 1'b1;
            r_out_cnt <= '0;
          end else begin
            // Address for the next (ph,c) is formed one cycle ahead so o_rd_addr stays registered.
            if (r_rd_vld) begin
              case (r_ph)
                PH_ROW0: begin
                  r_ph      <= PH_ROW1;
                  o_rd_addr <= w_base1 + w_c_ext;
                end
                PH_ROW1: begin
                  r_ph      <= PH_ROW2;
                  o_rd_addr <= w_base2 + w_c_ext;
                end
                default: begin
                  r_ph <= PH_ROW0;
                  if (r_c == r_n - 10'd1) begin
                    r_rd_vld  <= 1'b0;
                    o_rd_addr <= '0;
                  end else begin
                    r_c       <= w_c_nxt;
                    o_rd_addr <= ADDR_W'(w_c_nxt);
                  end
                end
              endcase
            end
            if (w_col_vld) begin
              if (r_strb_cnt == r_n - 10'd1) begin
                r_state   <= ST_OUT;
                o_EOP     <= 1'b1;
                r_out_cnt <= '0;
              end else begin
                r_strb_cnt <= r_strb_cnt + 10'd1;
              end
            end
          end
        end
        ST_OUT: begin
          if (w_res_cnt == 10'd0) begin
            r_state <= ST_IDLE;
            o_EOP   <= 1'b0;
          end else if (i_valid) begin
            o_out_req  <= 1'b1;
            o_out_addr <= r_out_cnt;
            r_out_cnt  <= r_out_cnt + 10'd1;
            if (r_out_cnt == w_res_cnt - 10'd1) begin
              r_state <= ST_IDLE;
              o_EOP   <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  col_assembler #(
    .PIX_W  (PIX_W),
    .RD_LAT (RD_LAT)
  ) u_col_asm (
    .i_CLK       (i_CLK),
    .i_rst       (i_rst),
    .i_rd_vld    (r_rd_vld),
    .i_rd_ph     (r_ph),
    .i_mem_rdata (i_mem_rdata),
    .o_col       (o_col),
    .o_col_valid (w_col_vld)
  );

endmodule

// File: tb/tb_img_mem_fsm.sv
// Directed bench for img_mem_fsm with a 1-cycle-latency band BRAM model.
module tb_img_mem_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        valid;
  logic        run;
  logic [9:0]  img_len;
  logic [7:0]  pixel;
  logic [7:0]  mem_rdata;
  logic        we;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] rd_addr;
  logic [23:0] col;
  logic        col_valid;
  logic [9:0]  out_addr;
  logic        out_req;
  logic        eop;
  logic [1:0]  state;
  logic        overflow;

  logic [7:0]  mem [4096];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    mem_rdata <= mem[rd_addr];
  end

  img_mem_fsm dut (
    .i_CLK       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_valid     (valid),
    .i_run       (run),
    .i_imgLength (img_len),
    .i_pixel     (pixel),
    .i_mem_rdata (mem_rdata),
    .o_we        (we),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_rd_addr   (rd_addr),
    .o_col       (col),
    .o_col_valid (col_valid),
    .o_out_addr  (out_addr),
    .o_out_req   (out_req),
    .o_EOP       (eop),
    .o_state     (state),
    .o_overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nstrb;
    int eop_k;
    int nwr;
    int last_wa;
    logic [23:0] exp_col;

    rst = 1'b1; load = 0; valid = 0; run = 0; img_len = 10'd5; pixel = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_state", 32'(state), 0);
    check_val("rst_outs", {we, eop, overflow, col_valid, out_req}, 0);

    // Load N=5, pixels 1..15
    load = 1; tick(); load = 0;
    check_val("load_state", 32'(state), 1);
    for (int i = 1; i <= 15; i++) begin
      pixel = 8'(i); valid = 1; tick(); valid = 0;
      check_val("load_wr", {we, wr_addr, wr_data}, {1'b1, 12'(i - 1), 8'(i)});
      tick();
      check_val("load_we_low", 32'(we), 0);
    end
    check_val("load_ovf", 32'(overflow), 0);

    // Run: strobes at cycles 4,7,..,16 after entry; length change after entry is ignored
    run = 1; tick(); run = 0; img_len = 10'd7;
    check_val("run_state", 32'(state), 2);
    nstrb = 0; eop_k = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (col_valid) begin
        exp_col = {8'(nstrb + 11), 8'(nstrb + 6), 8'(nstrb + 1)};
        check_val("col_time", k, 4 + 3 * nstrb);
        check_val("col_data", 32'(col), 32'(exp_col));
        nstrb++;
      end
      if (eop && eop_k == 0) eop_k = k;
    end
    check_val("col_count", nstrb, 5);
    check_val("eop_time", eop_k, 17);
    check_val("out_state", 32'(state), 3);

    // Out: 3 results; i_load ignored
    load = 1; tick(); load = 0;
    check_val("out_load_ign", {30'd0, state}, 3);
    for (int j = 0; j < 3; j++) begin
      valid = 1; tick(); valid = 0;
      check_val("out_req", {out_req, out_addr}, {1'b1, 10'(j)});
      check_val("out_st_eop", {eop, state}, (j < 2) ? {1'b1, 2'd3} : {1'b0, 2'd0});
      tick();
      check_val("out_req_low", 32'(out_req), 0);
    end

    // Overflow: N=3, 10 pulses -> 9 writes
    img_len = 10'd3;
    load = 1; tick(); load = 0;
    nwr = 0; last_wa = -1;
    for (int i = 1; i <= 10; i++) begin
      pixel = 8'(100 + i); valid = 1; tick(); valid = 0;
      if (we) begin nwr++; last_wa = int'(wr_addr); end
      if (i == 9) check_val("ovf_before", 32'(overflow), 0);
      tick();
    end
    check_val("ovf_writes", nwr, 9);
    check_val("ovf_last_addr", last_wa, 8);
    check_val("ovf_sticky", 32'(overflow), 1);
    load = 1; tick(); load = 0;
    pixel = 8'hAA; valid = 1; tick(); valid = 0;
    check_val("restart_wr", {overflow, we, wr_addr, wr_data}, {1'b1, 1'b1, 12'd0, 8'hAA});

    // Edge: N=2, run wins over same-cycle valid
    img_len = 10'd2;
    run = 1; valid = 1; tick(); run = 0; valid = 0;
    check_val("edge_drop", {we, state}, {1'b0, 2'd2});
    tick();
    check_val("edge_out", {col_valid, eop, state}, {1'b0, 1'b1, 2'd3});
    tick();
    check_val("edge_idle", {col_valid, eop, state}, {1'b0, 1'b0, 2'd0});

    // Reset mid-RUN at column 2
    img_len = 10'd5;
    load = 1; tick(); load = 0;
    run = 1; tick(); run = 0;
    for (int k = 1; k <= 10; k++) tick();
    check_val("mid_strobe", 32'(col_valid), 1);
    rst = 1; tick(); rst = 0;
    check_val("mid_rst_state", 32'(state), 0);
    check_val("mid_rst_outs",
              {we, wr_addr, wr_data, rd_addr, col_valid, out_req, eop, overflow},
              0);
    check_val("mid_rst_col", 32'(col), 0);
    check_val("mid_rst_oaddr", 32'(out_addr), 0);
    nstrb = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (col_valid || state != 2'd0) nstrb++;
    end
    check_val("mid_rst_quiet", nstrb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
